// File: rtl/cp0_regfile_param.sv
// rtl/cp0_regfile_param.sv - parametrised MIPS32 CP0 register file with exception/ERET commit
// Holds Count/Compare/Status/Cause/EPC/BadVAddr and produces the interrupt and redirect requests.
module cp0_regfile_param #(
    parameter int          HW_INT_NUM = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] PRID_VAL   = 32'h004C0102,
    parameter logic [31:0] CONFIG_VAL = 32'h00008000,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [4:0]            raddr_i,
    input  logic [31:0]           data_i,
    input  logic [HW_INT_NUM-1:0] int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic                  eret_i,
    input  logic [31:0]           pc_i,
    input  logic                  in_delayslot_i,
    input  logic [31:0]           badvaddr_i,
    output logic [31:0]           data_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic [31:0]           count_o,
    output logic                  int_pending_o,
    output logic                  flush_o,
    output logic [31:0]           flush_pc_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] epc_q, epc_d;
    logic        presc_q, presc_d;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic        ti_q, ti_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exccode_q, exccode_d;

    logic        tick;
    logic [31:0] count_inc;
    logic [5:0]  hw_ext;
    logic [7:0]  ip;

    assign tick      = (COUNT_DIV == 1) ? 1'b1 : presc_q;
    assign count_inc = count_q + 32'd1;

    always_comb begin
        hw_ext = '0;
        hw_ext[HW_INT_NUM-1:0] = int_i;
    end

    // IP7 doubles as the timer interrupt line
    assign ip = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};

    assign status_o = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_o  = {bd_q, ti_q, 14'b0, ip, 1'b0, exccode_q, 2'b0};
    assign epc_o    = epc_q;
    assign count_o  = count_q;

    assign int_pending_o = ie_q & ~exl_q & (|(ip & im_q));

    assign flush_o    = exc_valid_i | eret_i;
    assign flush_pc_o = exc_valid_i ? EXC_VECTOR : (eret_i ? epc_q : 32'h0);

    always_comb begin
        data_o = 32'h0;
        case (raddr_i)
            5'd8:    data_o = badvaddr_q;
            5'd9:    data_o = count_q;
            5'd11:   data_o = compare_q;
            5'd12:   data_o = status_o;
            5'd13:   data_o = cause_o;
            5'd14:   data_o = epc_q;
            5'd15:   data_o = PRID_VAL;
            5'd16:   data_o = CONFIG_VAL;
            default: data_o = 32'h0;
        endcase
    end

    always_comb begin
        count_d    = tick ? count_inc : count_q;
        presc_d    = (COUNT_DIV == 1) ? 1'b0 : ~presc_q;
        compare_d  = compare_q;
        badvaddr_d = badvaddr_q;
        epc_d      = epc_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ti_d       = ti_q | (tick & (count_inc == compare_q));
        ip_hw_d    = hw_ext;
        ip_sw_d    = ip_sw_q;
        exccode_d  = exccode_q;

        if (exc_valid_i) begin
            // a nested exception must not clobber the original return address
            if (!exl_q) begin
                epc_d = in_delayslot_i ? (pc_i - 32'd4) : pc_i;
                bd_d  = in_delayslot_i;
            end
            exl_d     = 1'b1;
            exccode_d = exc_code_i;
            if (exc_code_i == 5'd4 || exc_code_i == 5'd5)
                badvaddr_d = badvaddr_i;
        end else if (eret_i) begin
            exl_d = 1'b0;
        end else if (we_i) begin
            case (waddr_i)
                5'd9: begin
                    count_d = data_i;
                    presc_d = 1'b0;
                end
                5'd11: begin
                    compare_d = data_i;
                    ti_d      = 1'b0;
                end
                5'd12: begin
                    im_d  = data_i[15:8];
                    exl_d = data_i[1];
                    ie_d  = data_i[0];
                end
                5'd13:   ip_sw_d = data_i[9:8];
                5'd14:   epc_d   = data_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= 32'h0;
            compare_q  <= 32'h0;
            badvaddr_q <= 32'h0;
            epc_q      <= 32'h0;
            presc_q    <= 1'b0;
            im_q       <= 8'h0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_hw_q    <= 6'h0;
            ip_sw_q    <= 2'h0;
            exccode_q  <= 5'h0;
        end else begin
            count_q    <= count_d;
            compare_q  <= compare_d;
            badvaddr_q <= badvaddr_d;
            epc_q      <= epc_d;
            presc_q    <= presc_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
        end
    end

endmodule

// File: tb/tb_cp0_regfile_param.sv
// tb/tb_cp0_regfile_param.sv - directed self-checking bench for cp0_regfile_param
// Two instances: default parameters, and HW_INT_NUM=2 with an undivided Count.
module tb_cp0_regfile_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0, eret = 1'b0, exc_valid = 1'b0, in_ds = 1'b0;
    logic [4:0]  waddr = '0, raddr = '0, exc_code = '0;
    logic [31:0] wdata = '0, pc = '0, badv = '0;
    logic [5:0]  int_in = '0;
    logic [31:0] data_o, status_o, cause_o, epc_o, count_o, flush_pc_o;
    logic        int_pending_o, flush_o;

    logic        we2 = 1'b0;
    logic [4:0]  waddr2 = '0, raddr2 = '0;
    logic [31:0] wdata2 = '0;
    logic [1:0]  int2 = '0;
    logic [31:0] data2_o, status2_o, cause2_o, epc2_o, count2_o, flush_pc2_o;
    logic        int_pending2_o, flush2_o;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cp0_regfile_param dut (
        .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .raddr_i(raddr), .data_i(wdata),
        .int_i(int_in), .exc_valid_i(exc_valid), .exc_code_i(exc_code), .eret_i(eret),
        .pc_i(pc), .in_delayslot_i(in_ds), .badvaddr_i(badv), .data_o(data_o),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .count_o(count_o),
        .int_pending_o(int_pending_o), .flush_o(flush_o), .flush_pc_o(flush_pc_o)
    );

    cp0_regfile_param #(.HW_INT_NUM(2), .COUNT_DIV(1)) dut2 (
        .clk(clk), .rst(rst), .we_i(we2), .waddr_i(waddr2), .raddr_i(raddr2), .data_i(wdata2),
        .int_i(int2), .exc_valid_i(1'b0), .exc_code_i(5'd0), .eret_i(1'b0),
        .pc_i(32'h0), .in_delayslot_i(1'b0), .badvaddr_i(32'h0), .data_o(data2_o),
        .status_o(status2_o), .cause_o(cause2_o), .epc_o(epc2_o), .count_o(count2_o),
        .int_pending_o(int_pending2_o), .flush_o(flush2_o), .flush_pc_o(flush_pc2_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (status_o !== 32'h0040_0000) begin bad++; $display("FAIL reset_status got=%h exp=%h", status_o, 32'h0040_0000); end
        total++; if (cause_o !== 32'h0) begin bad++; $display("FAIL reset_cause got=%h exp=0", cause_o); end
        total++; if (count_o !== 32'h0) begin bad++; $display("FAIL reset_count got=%h exp=0", count_o); end
        total++; if (int_pending_o !== 1'b0 || flush_o !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", int_pending_o, flush_o); end
        raddr = 5'd15; #1;
        total++; if (data_o !== 32'h004C0102) begin bad++; $display("FAIL read_prid got=%h exp=004c0102", data_o); end
        raddr = 5'd16; #1;
        total++; if (data_o !== 32'h00008000) begin bad++; $display("FAIL read_config got=%h exp=00008000", data_o); end
    endtask

    task automatic test_count();
        repeat (10) step();
        total++; if (count_o !== 32'd5) begin bad++; $display("FAIL count_div2 got=%0d exp=5", count_o); end
        we = 1'b1; waddr = 5'd9; wdata = 32'hFFFF_FFFF;
        step();
        we = 1'b0;
        total++; if (count_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL count_load got=%h exp=ffffffff", count_o); end
        step(); step();
        total++; if (count_o !== 32'h0) begin bad++; $display("FAIL count_wrap got=%h exp=0", count_o); end
    endtask

    task automatic test_timer();
        int n;
        do_reset();
        we = 1'b1; waddr = 5'd11; wdata = 32'd3;
        step();
        waddr = 5'd12; wdata = 32'h0000_8001;
        step();
        we = 1'b0;
        n = 0;
        while (count_o !== 32'd3 && n < 20) begin step(); n++; end
        total++; if (count_o !== 32'd3) begin bad++; $display("FAIL timer_wait got=%0d exp=3", count_o); end
        total++; if (cause_o[30] !== 1'b1 || cause_o[15] !== 1'b1) begin bad++; $display("FAIL timer_ti got=%h exp=ti+ip7 set", cause_o); end
        total++; if (int_pending_o !== 1'b1) begin bad++; $display("FAIL timer_pending got=%b exp=1", int_pending_o); end
        we = 1'b1; waddr = 5'd11; wdata = 32'd100;
        step();
        we = 1'b0;
        total++; if (cause_o[30] !== 1'b0 || int_pending_o !== 1'b0) begin bad++; $display("FAIL timer_clear got=%b%b exp=00", cause_o[30], int_pending_o); end
    endtask

    task automatic test_exception();
        exc_valid = 1'b1; exc_code = 5'd4; pc = 32'h8000_0104; in_ds = 1'b1; badv = 32'h1235;
        #1;
        total++; if (flush_o !== 1'b1 || flush_pc_o !== 32'hBFC0_0380) begin bad++; $display("FAIL exc_redirect got=%b %h exp=1 bfc00380", flush_o, flush_pc_o); end
        step();
        exc_valid = 1'b0; in_ds = 1'b0;
        raddr = 5'd8; #1;
        total++; if (epc_o !== 32'h8000_0100) begin bad++; $display("FAIL exc_epc got=%h exp=80000100", epc_o); end
        total++; if (cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'd4) begin bad++; $display("FAIL exc_cause got=%h exp=bd=1 code=4", cause_o); end
        total++; if (data_o !== 32'h1235) begin bad++; $display("FAIL exc_badvaddr got=%h exp=1235", data_o); end
        total++; if (status_o[1] !== 1'b1) begin bad++; $display("FAIL exc_exl got=%b exp=1", status_o[1]); end
    endtask

    task automatic test_nested_eret();
        exc_valid = 1'b1; exc_code = 5'd8; pc = 32'h9000_0000; badv = 32'h5555;
        step();
        exc_valid = 1'b0;
        raddr = 5'd8; #1;
        total++; if (epc_o !== 32'h8000_0100) begin bad++; $display("FAIL nested_epc got=%h exp=80000100", epc_o); end
        total++; if (cause_o[6:2] !== 5'd8 || cause_o[31] !== 1'b1) begin bad++; $display("FAIL nested_cause got=%h exp=bd=1 code=8", cause_o); end
        total++; if (data_o !== 32'h1235) begin bad++; $display("FAIL nested_badvaddr got=%h exp=1235", data_o); end
        eret = 1'b1; #1;
        total++; if (flush_o !== 1'b1 || flush_pc_o !== 32'h8000_0100) begin bad++; $display("FAIL eret_redirect got=%b %h exp=1 80000100", flush_o, flush_pc_o); end
        step();
        eret = 1'b0; #1;
        total++; if (status_o[1] !== 1'b0 || flush_o !== 1'b0) begin bad++; $display("FAIL eret_exl got=%b%b exp=00", status_o[1], flush_o); end
    endtask

    task automatic test_priority_masks();
        we = 1'b1; waddr = 5'd12; wdata = 32'hFFFF_FFFF;
        exc_valid = 1'b1; exc_code = 5'd0; pc = 32'h0000_2000;
        step();
        exc_valid = 1'b0;
        total++; if (status_o !== 32'h0040_8003) begin bad++; $display("FAIL prio_status got=%h exp=00408003", status_o); end
        total++; if (epc_o !== 32'h0000_2000) begin bad++; $display("FAIL prio_epc got=%h exp=00002000", epc_o); end
        raddr = 5'd12; #1;
        total++; if (data_o !== 32'h0040_8003) begin bad++; $display("FAIL nobypass got=%h exp=00408003", data_o); end
        step();
        total++; if (status_o !== 32'h0040_FF03) begin bad++; $display("FAIL status_mask got=%h exp=0040ff03", status_o); end
        waddr = 5'd13;
        step();
        total++; if (cause_o !== 32'h0000_0300) begin bad++; $display("FAIL cause_mask got=%h exp=00000300", cause_o); end
        waddr = 5'd8;
        step();
        waddr = 5'd5;
        step();
        we = 1'b0;
        raddr = 5'd8; #1;
        total++; if (data_o !== 32'h1235) begin bad++; $display("FAIL badvaddr_ro got=%h exp=1235", data_o); end
        raddr = 5'd5; #1;
        total++; if (data_o !== 32'h0) begin bad++; $display("FAIL unmapped got=%h exp=0", data_o); end
    endtask

    task automatic test_hw_int_async_reset();
        do_reset();
        repeat (4) step();
        total++; if (count2_o !== 32'd4) begin bad++; $display("FAIL count_div1 got=%0d exp=4", count2_o); end
        we2 = 1'b1; waddr2 = 5'd12; wdata2 = 32'h0000_0801; int2 = 2'b10;
        step();
        we2 = 1'b0;
        total++; if (cause2_o !== 32'h0000_0800) begin bad++; $display("FAIL hwint_cause got=%h exp=00000800", cause2_o); end
        total++; if (int_pending2_o !== 1'b1) begin bad++; $display("FAIL hwint_pending got=%b exp=1", int_pending2_o); end
        we = 1'b1; waddr = 5'd12; wdata = 32'h0000_FF01;
        step();
        we = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++; if (status2_o !== 32'h0040_0000 || cause2_o !== 32'h0 || count2_o !== 32'h0 || int_pending2_o !== 1'b0) begin bad++; $display("FAIL async_reset2 got=%h %h %h %b exp=00400000 0 0 0", status2_o, cause2_o, count2_o, int_pending2_o); end
        total++; if (status_o !== 32'h0040_0000 || epc_o !== 32'h0 || count_o !== 32'h0) begin bad++; $display("FAIL async_reset1 got=%h %h %h exp=00400000 0 0", status_o, epc_o, count_o); end
        int2 = 2'b00;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_count();
        test_timer();
        test_exception();
        test_nested_eret();
        test_priority_masks();
        test_hw_int_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
